// File: rtl/rs_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rs_table                                                        |
// | Purpose  : Reservation station table; dual dispatch, wakeup snoop, one    |
// |            registered issue per FU per cycle.                             |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+

package rs_table_pkg;
  localparam int TAG_W = 6;
  localparam int FU_W  = 2;

  typedef struct packed {
    logic             valid;
    logic [FU_W-1:0]  fu;
    logic [7:0]       op;
    logic [TAG_W-1:0] rd;
    logic [TAG_W-1:0] rs1;
    logic             src1rdy;
    logic [TAG_W-1:0] rs2;
    logic             src2rdy;
  } rs_entry_t;
endpackage

module rs_table
  import rs_table_pkg::*;
#(
  parameter int RS_DEPTH = 16,
  parameter int NUM_FU   = 3,
  parameter int PREG_W   = TAG_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  rs_entry_t                   rs_in_a,
  input  rs_entry_t                   rs_in_b,
  input  logic [NUM_FU-1:0]           wake_valid,
  input  logic [NUM_FU*PREG_W-1:0]    wake_preg,
  input  logic [NUM_FU-1:0]           fu_ready,
  output logic [NUM_FU-1:0]           issue_valid,
  output rs_entry_t                   issue_entry [NUM_FU],
  output logic [$clog2(RS_DEPTH):0]   rs_count,
  output logic                        rs_full,
  output logic                        overflow_err
);

  localparam int c_idx_w = $clog2(RS_DEPTH);
  localparam int c_cnt_w = c_idx_w + 1;

  rs_entry_t                r_tab [RS_DEPTH];
  logic [NUM_FU-1:0]        r_issue_valid;
  rs_entry_t                r_issue_entry [NUM_FU];
  logic [c_cnt_w-1:0]       r_count;
  logic                     r_ovf;

  logic [c_cnt_w-1:0]       w_free_cnt;
  logic                     w_free0_ok;
  logic                     w_free1_ok;
  logic [c_idx_w-1:0]       w_free0;
  logic [c_idx_w-1:0]       w_free1;
  logic [1:0]               w_num_in;
  logic                     w_accept;
  logic                     w_wr_a;
  logic                     w_wr_b;
  logic [c_idx_w-1:0]       w_slot_a;
  logic [c_idx_w-1:0]       w_slot_b;
  rs_entry_t                w_new_a;
  rs_entry_t                w_new_b;
  logic [RS_DEPTH-1:0]      w_hit1;
  logic [RS_DEPTH-1:0]      w_hit2;
  logic                     w_cand_ok  [NUM_FU];
  logic [c_idx_w-1:0]       w_cand_idx [NUM_FU];
  logic [NUM_FU-1:0]        w_fire;
  logic [c_cnt_w-1:0]       w_issue_cnt;

  // True when any FU broadcasts completion of this tag this cycle.
  function automatic logic f_hit(input logic [TAG_W-1:0] tag);
    f_hit = 1'b0;
    for (int f = 0; f < NUM_FU; f++) begin
      if (wake_valid[f] && (wake_preg[f*PREG_W +: PREG_W] == tag)) f_hit = 1'b1;
    end
  endfunction

  always_comb begin
    w_free_cnt = '0;
    w_free0_ok = 1'b0;
    w_free1_ok = 1'b0;
    w_free0    = '0;
    w_free1    = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!r_tab[i].valid) begin
        w_free_cnt = w_free_cnt + c_cnt_w'(1);
        if (!w_free0_ok) begin
          w_free0_ok = 1'b1;
          w_free0    = c_idx_w'(i);
        end else if (!w_free1_ok) begin
          w_free1_ok = 1'b1;
          w_free1    = c_idx_w'(i);
        end
      end
    end
  end

  assign w_num_in = {1'b0, rs_in_a.valid} + {1'b0, rs_in_b.valid};
  assign w_accept = (w_free_cnt >= c_cnt_w'(w_num_in));
  assign w_wr_a   = w_accept && rs_in_a.valid;
  assign w_wr_b   = w_accept && rs_in_b.valid;
  assign w_slot_a = w_free0;
  assign w_slot_b = rs_in_a.valid ? w_free1 : w_free0;

  // Incoming operands completing in the dispatch cycle are captured here.
  always_comb begin
    w_new_a         = rs_in_a;
    w_new_a.src1rdy = rs_in_a.src1rdy | f_hit(rs_in_a.rs1);
    w_new_a.src2rdy = rs_in_a.src2rdy | f_hit(rs_in_a.rs2);
    w_new_b         = rs_in_b;
    w_new_b.src1rdy = rs_in_b.src1rdy | f_hit(rs_in_b.rs1);
    w_new_b.src2rdy = rs_in_b.src2rdy | f_hit(rs_in_b.rs2);
  end

  always_comb begin
    w_hit1 = '0;
    w_hit2 = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_hit1[i] = r_tab[i].valid && !r_tab[i].src1rdy && f_hit(r_tab[i].rs1);
      w_hit2[i] = r_tab[i].valid && !r_tab[i].src2rdy && f_hit(r_tab[i].rs2);
    end
  end

  for (genvar f = 0; f < NUM_FU; f++) begin : g_sel
    always_comb begin
      w_cand_ok[f]  = 1'b0;
      w_cand_idx[f] = '0;
      for (int i = RS_DEPTH - 1; i >= 0; i--) begin
        if (r_tab[i].valid && r_tab[i].src1rdy && r_tab[i].src2rdy &&
            (r_tab[i].fu == FU_W'(f))) begin
          w_cand_ok[f]  = 1'b1;
          w_cand_idx[f] = c_idx_w'(i);
        end
      end
    end
    assign w_fire[f] = w_cand_ok[f] && fu_ready[f];
  end

  always_comb begin
    w_issue_cnt = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      if (w_fire[f]) w_issue_cnt = w_issue_cnt + c_cnt_w'(1);
    end
  end

  // Writes only target slots free before this edge, so they never collide with issue frees.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RS_DEPTH; i++) r_tab[i] <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (w_hit1[i]) r_tab[i].src1rdy <= 1'b1;
        if (w_hit2[i]) r_tab[i].src2rdy <= 1'b1;
      end
      for (int f = 0; f < NUM_FU; f++) begin
        if (w_fire[f]) r_tab[w_cand_idx[f]].valid <= 1'b0;
      end
      if (w_wr_a) r_tab[w_slot_a] <= w_new_a;
      if (w_wr_b) r_tab[w_slot_b] <= w_new_b;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_issue_valid <= '0;
      for (int f = 0; f < NUM_FU; f++) r_issue_entry[f] <= '0;
    end else begin
      for (int f = 0; f < NUM_FU; f++) begin
        r_issue_valid[f] <= w_fire[f];
        if (w_fire[f]) r_issue_entry[f] <= r_tab[w_cand_idx[f]];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= r_count + (w_accept ? c_cnt_w'(w_num_in) : '0) - w_issue_cnt;
      if (!w_accept) r_ovf <= 1'b1;
    end
  end

  assign issue_valid  = r_issue_valid;
  assign issue_entry  = r_issue_entry;
  assign rs_count     = r_count;
  assign rs_full      = (w_free_cnt < c_cnt_w'(2));
  assign overflow_err = r_ovf;

endmodule
`default_nettype wire
